vending_machine_gen: RTL and testbench
======================================

# vending_machine_gen

Parametrised coin-operated vending controller, the next generation of the team's fixed 5/10/20 vending machine. It accepts coins of value 5, 10 or 20 through a valid-qualified input, accumulates credit, and dispenses once credit reaches a configurable price. Any excess credit is returned as a registered one-coin-per-cycle change stream, and a cancel request refunds the full credit the same way. A wrapping vend counter is also provided. The block sits between the coin-acceptor front end and the dispense/change actuators.

## Interface
- PRICE, 15: item price; multiple of 5, range 5..(2^CREDIT_W − 21)
- CREDIT_W, 8: width of credit accumulator
- CNT_W, 16: width of vend counter
- clk  in  1  rising-edge clock (single clock domain)
- reset_n  in  1  asynchronous, active-low reset
- coin_valid  in  1  coin_value is valid this cycle
- coin_value  in  5  coin denomination; legal values 5, 10, 20
- cancel  in  1  refund request, level sampled each cycle
- ready  out  1  high in IDLE/COLLECT; coins accepted only when high
- coin_reject  out  1  one-cycle pulse: sampled coin not accepted
- dispense  out  1  one-cycle pulse: release one item
- change_valid  out  1  change_value is a coin to return this cycle
- change_value  out  5  returned coin: 20, 10 or 5; 0 when change_valid low
- credit  out  CREDIT_W  current accumulated credit
- vend_count  out  CNT_W  items dispensed since reset, wraps modulo 2^CNT_W

## Operation
- Reset (async assert, sync release): state IDLE, credit 0, vend_count 0, all pulse outputs 0, change_value 0, ready 1.
- Four states:
  - IDLE: credit 0.
  - COLLECT: 0 < credit < PRICE.
  - DISPENSE.
  - CHANGE.
- In IDLE/COLLECT, coin_valid with a legal value adds it to credit.
  - If the new credit ≥ PRICE: next state DISPENSE, credit ← new credit − PRICE.
  - Else: next state COLLECT.
- Illegal coin_value (anything other than 5, 10 or 20) with coin_valid: coin_reject pulses, credit unchanged.
- coin_valid while ready=0 (DISPENSE/CHANGE): coin_reject pulses, coin ignored.
- DISPENSE (one cycle): dispense=1, vend_count increments (wraps to 0 from all-ones). Next state is CHANGE if credit > 0, else IDLE.
- CHANGE: each cycle emit the largest coin ≤ credit (greedy 20, then 10, then 5), change_valid=1, and subtract it from credit. Exit to IDLE in the cycle after credit reaches 0.
- cancel in COLLECT: next state CHANGE, refunding the full credit. No dispense and no vend_count change.
- cancel in IDLE: no effect.
- cancel in DISPENSE/CHANGE: ignored.
- cancel and coin_valid in the same COLLECT/IDLE cycle: cancel wins, coin_reject pulses, coin not added.
- Credit arithmetic is computed CREDIT_W+1 bits wide. Since PRICE ≤ 2^CREDIT_W − 21, no overflow is possible.
- reset_n assertion mid-CHANGE or mid-DISPENSE aborts immediately. Remaining credit is lost and outputs return to reset values.

## Timing
- All outputs are registered. No combinational input→output paths.
- Coin sampled at edge N → credit, coin_reject and state visible after edge N (cycle N+1).
- Price reached at edge N: dispense high in cycle N+1, first change coin in cycle N+2, ready low from cycle N+1 until the cycle after the last change coin.
- Dispense-to-IDLE latency: 1 cycle when there is no change; otherwise 1 + number of change coins.
- Back-to-back coins are accepted every cycle while ready=1.

## Structure
- Shared package vending_pkg holds:
  - state enum (IDLE, COLLECT, DISPENSE, CHANGE)
  - coin constants COIN_5=5, COIN_10=10, COIN_20=20
  - function is_legal_coin
- One natural sub-module: change_gen. It is a combinational greedy selector from credit to the next coin value, instantiated by the FSM.
- FSM, credit register and vend counter live in vending_machine_gen.

## Test plan
- PRICE=15, coins 10 then 5 → dispense pulse 1 cycle after the 5 coin, no change_valid, vend_count=1, credit=0, back to IDLE.
- PRICE=15, coin 20 → dispense, then one change coin of 5, credit 0, IDLE.
- PRICE=35, coins 20,20 then cancel before the second coin is added? No: coins 20 then cancel → change 20, no dispense, vend_count unchanged. Coins 20,20 → dispense, change 5.
- PRICE=15, coin 7 (illegal) → coin_reject pulse, credit stays 0. Coin 10 during CHANGE → coin_reject pulse, change sequence unaffected.
- PRICE=5, CNT_W=2: five purchases of 5 → vend_count 1,2,3,0,1 (wrap checked).
- PRICE=35, coins 20 then 10, then cancel and coin 5 in the same cycle → coin_reject; refund change 20 then 10; state IDLE. Separately, assert reset_n mid-CHANGE → all outputs 0, credit 0 immediately.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller family.
package vending_pkg;

  localparam int COIN_W = 5;

  localparam logic [COIN_W-1:0] COIN_5  = 5'd5;
  localparam logic [COIN_W-1:0] COIN_10 = 5'd10;
  localparam logic [COIN_W-1:0] COIN_20 = 5'd20;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE
  } state_t;

  // Only the three physical denominations the acceptor can report are legal.
  function automatic logic is_legal_coin(input logic [COIN_W-1:0] value);
    return (value == COIN_5) || (value == COIN_10) || (value == COIN_20);
  endfunction

endpackage

// File: rtl/vending_machine_gen_if.sv
// Coin-in / dispense-and-change-out bundle between the acceptor front end,
// the controller and the actuators.
interface vending_machine_gen_if #(
  parameter int CREDIT_W = 8,
  parameter int CNT_W    = 16
);
  import vending_pkg::*;

  logic                coin_valid;
  logic [COIN_W-1:0]   coin_value;
  logic                cancel;
  logic                ready;
  logic                coin_reject;
  logic                dispense;
  logic                change_valid;
  logic [COIN_W-1:0]   change_value;
  logic [CREDIT_W-1:0] credit;
  logic [CNT_W-1:0]    vend_count;

  // Coin acceptor side.
  modport master (
    output coin_valid, coin_value, cancel,
    input  ready, coin_reject, dispense, change_valid, change_value,
           credit, vend_count
  );

  // Controller side.
  modport slave (
    input  coin_valid, coin_value, cancel,
    output ready, coin_reject, dispense, change_valid, change_value,
           credit, vend_count
  );
endinterface

// File: rtl/vending_machine_gen_change_gen.sv
// Greedy change selector: largest coin not exceeding the remaining credit.
module change_gen
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [COIN_W-1:0]   coin
);

  // Pick 20, then 10, then 5; credit is always a multiple of 5.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    coin = '0;
    if (credit >= CREDIT_W'(COIN_20))      coin = COIN_20;
    else if (credit >= CREDIT_W'(COIN_10)) coin = COIN_10;
    else if (credit >= CREDIT_W'(COIN_5))  coin = COIN_5;
  end

endmodule

// File: rtl/vending_machine_gen.sv
// Parametrised vending controller: collects coins, dispenses at PRICE,
// returns excess or cancelled credit one coin per cycle. All outputs are
// registered; each output register is loaded with the value belonging to
// the state being entered.
module vending_machine_gen
  import vending_pkg::*;
#(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vending_machine_gen_if.slave  bus
);

  localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);

  state_t              state_q, state_next;
  logic [CREDIT_W-1:0] credit_q, credit_next;
  logic [CNT_W-1:0]    count_q, count_next;
  logic                ready_q, ready_next;
  logic                reject_q, reject_next;
  logic                dispense_q, dispense_next;
  logic                chg_valid_q, chg_valid_next;
  logic [COIN_W-1:0]   chg_value_q, chg_value_next;
  logic [COIN_W-1:0]   next_coin;
  logic [CREDIT_W:0]   sum;
  logic                emit;

  change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
    .credit (credit_q),
    .coin   (next_coin)
  );

  // One extra bit so the credit + coin comparison against PRICE cannot wrap.
  assign sum = {1'b0, credit_q} + (CREDIT_W+1)'(bus.coin_value);

  // Next state, next credit/count and next registered output values.
  always_comb begin
    state_next     = state_q;
    credit_next    = credit_q;
    count_next     = count_q;
    reject_next    = 1'b0;
    dispense_next  = 1'b0;
    chg_valid_next = 1'b0;
    chg_value_next = '0;
    emit           = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (bus.cancel) begin
          // Cancel beats a simultaneous coin; cancel from IDLE does nothing.
          reject_next = bus.coin_valid;
          if (state_q == COLLECT) begin
            state_next = CHANGE;
            emit       = 1'b1;
          end
        end else if (bus.coin_valid) begin
          if (!is_legal_coin(bus.coin_value)) begin
            reject_next = 1'b1;
          end else if (sum >= PRICE_W) begin
            state_next    = DISPENSE;
            credit_next   = CREDIT_W'(sum - PRICE_W);
            dispense_next = 1'b1;
            count_next    = count_q + CNT_W'(1);
          end else begin
            state_next  = COLLECT;
            credit_next = CREDIT_W'(sum);
          end
        end
      end
      DISPENSE, CHANGE: begin
        // Not ready: any coin is bounced, cancel is ignored.
        reject_next = bus.coin_valid;
        if (credit_q != '0) begin
          state_next = CHANGE;
          emit       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Hand back the next greedy coin and take it off the credit.
    if (emit) begin
      chg_valid_next = 1'b1;
      chg_value_next = next_coin;
      credit_next    = credit_q - CREDIT_W'(next_coin);
    end
  end

  assign ready_next = (state_next == IDLE) || (state_next == COLLECT);

  // State, datapath and output registers; reset aborts any vend in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      reject_q    <= 1'b0;
      dispense_q  <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_value_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_next;
      credit_q    <= credit_next;
      count_q     <= count_next;
      ready_q     <= ready_next;
      reject_q    <= reject_next;
      dispense_q  <= dispense_next;
      chg_valid_q <= chg_valid_next;
      chg_value_q <= chg_value_next;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.coin_reject  = reject_q;
  assign bus.dispense     = dispense_q;
  assign bus.change_valid = chg_valid_q;
  assign bus.change_value = chg_value_q;
  assign bus.credit       = credit_q;
  assign bus.vend_count   = count_q;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Directed bench for vending_machine_gen: three configurations
// (PRICE 15, PRICE 35, PRICE 5 with a 2-bit vend counter).
module tb_vending_machine_gen;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  vending_machine_gen_if #(.CREDIT_W(8), .CNT_W(16)) b15 ();
  vending_machine_gen_if #(.CREDIT_W(8), .CNT_W(16)) b35 ();
  vending_machine_gen_if #(.CREDIT_W(8), .CNT_W(2))  b5  ();

  vending_machine_gen #(.PRICE(15), .CREDIT_W(8), .CNT_W(16)) u15 (
    .clk(clk), .reset_n(reset_n), .bus(b15));
  vending_machine_gen #(.PRICE(35), .CREDIT_W(8), .CNT_W(16)) u35 (
    .clk(clk), .reset_n(reset_n), .bus(b35));
  vending_machine_gen #(.PRICE(5), .CREDIT_W(8), .CNT_W(2)) u5 (
    .clk(clk), .reset_n(reset_n), .bus(b5));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle outputs before sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive15(input logic v, input logic [4:0] val, input logic c);
    b15.coin_valid = v; b15.coin_value = val; b15.cancel = c;
  endtask

  task automatic drive35(input logic v, input logic [4:0] val, input logic c);
    b35.coin_valid = v; b35.coin_value = val; b35.cancel = c;
  endtask

  task automatic drive5(input logic v, input logic [4:0] val, input logic c);
    b5.coin_valid = v; b5.coin_value = val; b5.cancel = c;
  endtask

  initial begin
    reset_n = 1'b0;
    drive15(0, 0, 0);
    drive35(0, 0, 0);
    drive5(0, 0, 0);
    repeat (2) tick;

    // Reset values
    check("rst_ready",     b15.ready, 1);
    check("rst_credit",    b15.credit, 0);
    check("rst_count",     b15.vend_count, 0);
    check("rst_dispense",  b15.dispense, 0);
    check("rst_chg_valid", b15.change_valid, 0);
    check("rst_chg_value", b15.change_value, 0);
    check("rst_reject",    b15.coin_reject, 0);
    check("rst_ready35",   b35.ready, 1);
    reset_n = 1'b1;
    tick;

    // PRICE 15: 10 then 5, exact price
    drive15(1, 10, 0); tick;
    check("p15_c10_credit", b15.credit, 10);
    check("p15_c10_ready",  b15.ready, 1);
    check("p15_c10_reject", b15.coin_reject, 0);
    drive15(1, 5, 0); tick;
    check("p15_c5_dispense",  b15.dispense, 1);
    check("p15_c5_credit",    b15.credit, 0);
    check("p15_c5_ready",     b15.ready, 0);
    check("p15_c5_count",     b15.vend_count, 1);
    check("p15_c5_chg_valid", b15.change_valid, 0);
    drive15(0, 0, 0); tick;
    check("p15_idle_dispense",  b15.dispense, 0);
    check("p15_idle_ready",     b15.ready, 1);
    check("p15_idle_chg_valid", b15.change_valid, 0);

    // PRICE 15: single 20 -> dispense then change 5
    drive15(1, 20, 0); tick;
    check("p15_c20_dispense", b15.dispense, 1);
    check("p15_c20_credit",   b15.credit, 5);
    check("p15_c20_count",    b15.vend_count, 2);
    drive15(0, 0, 0); tick;
    check("p15_c20_chg_valid", b15.change_valid, 1);
    check("p15_c20_chg_value", b15.change_value, 5);
    check("p15_c20_chg_cred",  b15.credit, 0);
    check("p15_c20_chg_ready", b15.ready, 0);
    tick;
    check("p15_c20_end_valid", b15.change_valid, 0);
    check("p15_c20_end_value", b15.change_value, 0);
    check("p15_c20_end_ready", b15.ready, 1);

    // PRICE 15: illegal coin value
    drive15(1, 7, 0); tick;
    check("p15_ill_reject", b15.coin_reject, 1);
    check("p15_ill_credit", b15.credit, 0);
    check("p15_ill_ready",  b15.ready, 1);
    drive15(0, 0, 0); tick;
    check("p15_ill_clear", b15.coin_reject, 0);

    // PRICE 15: 10 + 20 = 30 -> change 10, 5; coin during CHANGE bounced
    drive15(1, 10, 0); tick;
    drive15(1, 20, 0); tick;
    check("p15_30_dispense", b15.dispense, 1);
    check("p15_30_credit",   b15.credit, 15);
    check("p15_30_count",    b15.vend_count, 3);
    drive15(0, 0, 0); tick;
    check("p15_30_chg1", b15.change_value, 10);
    check("p15_30_cred1", b15.credit, 5);
    drive15(1, 10, 0); tick;
    check("p15_30_chg2",    b15.change_value, 5);
    check("p15_30_valid2",  b15.change_valid, 1);
    check("p15_30_reject",  b15.coin_reject, 1);
    check("p15_30_cred2",   b15.credit, 0);
    check("p15_30_ready2",  b15.ready, 0);
    drive15(0, 0, 0); tick;
    check("p15_30_end_valid",  b15.change_valid, 0);
    check("p15_30_end_ready",  b15.ready, 1);
    check("p15_30_end_reject", b15.coin_reject, 0);
    check("p15_30_end_credit", b15.credit, 0);

    // PRICE 35: cancel in IDLE has no effect
    drive35(0, 0, 1); tick;
    check("p35_idle_cancel_valid", b35.change_valid, 0);
    check("p35_idle_cancel_ready", b35.ready, 1);
    // PRICE 35: 20 then cancel -> refund 20
    drive35(1, 20, 0); tick;
    check("p35_c20_credit", b35.credit, 20);
    drive35(0, 0, 1); tick;
    check("p35_cancel_valid",    b35.change_valid, 1);
    check("p35_cancel_value",    b35.change_value, 20);
    check("p35_cancel_credit",   b35.credit, 0);
    check("p35_cancel_dispense", b35.dispense, 0);
    check("p35_cancel_ready",    b35.ready, 0);
    drive35(0, 0, 0); tick;
    check("p35_cancel_end_ready", b35.ready, 1);
    check("p35_cancel_end_valid", b35.change_valid, 0);
    check("p35_cancel_count",     b35.vend_count, 0);

    // PRICE 35: 20, 20 -> dispense, change 5
    drive35(1, 20, 0); tick;
    drive35(1, 20, 0); tick;
    check("p35_40_dispense", b35.dispense, 1);
    check("p35_40_credit",   b35.credit, 5);
    check("p35_40_count",    b35.vend_count, 1);
    drive35(0, 0, 0); tick;
    check("p35_40_chg", b35.change_value, 5);
    tick;
    check("p35_40_end_ready", b35.ready, 1);

    // PRICE 35: 20, 10, then cancel with coin 5 in the same cycle
    drive35(1, 20, 0); tick;
    drive35(1, 10, 0); tick;
    check("p35_30_credit", b35.credit, 30);
    drive35(1, 5, 1); tick;
    check("p35_cc_reject", b35.coin_reject, 1);
    check("p35_cc_chg1",   b35.change_value, 20);
    check("p35_cc_cred1",  b35.credit, 10);
    drive35(0, 0, 0); tick;
    check("p35_cc_chg2",   b35.change_value, 10);
    check("p35_cc_rej2",   b35.coin_reject, 0);
    check("p35_cc_cred2",  b35.credit, 0);
    tick;
    check("p35_cc_end_ready", b35.ready, 1);
    check("p35_cc_end_valid", b35.change_valid, 0);
    check("p35_cc_count",     b35.vend_count, 1);

    // PRICE 5, 2-bit counter: five purchases wrap the count
    for (int i = 0; i < 5; i++) begin
      drive5(1, 5, 0); tick;
      check("p5_dispense", b5.dispense, 1);
      check("p5_count",    b5.vend_count, (i + 1) % 4);
      drive5(0, 0, 0); tick;
      check("p5_idle_ready", b5.ready, 1);
    end

    // Reset asserted mid-CHANGE aborts immediately
    drive15(1, 10, 0); tick;
    drive15(1, 20, 0); tick;
    drive15(0, 0, 0); tick;
    check("mid_chg_valid", b15.change_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid",  b15.change_valid, 0);
    check("mid_rst_value",  b15.change_value, 0);
    check("mid_rst_credit", b15.credit, 0);
    check("mid_rst_ready",  b15.ready, 1);
    check("mid_rst_count",  b15.vend_count, 0);
    check("mid_rst_count5", b5.vend_count, 0);
    #1;
    reset_n = 1'b1;
    tick;
    check("post_rst_valid", b15.change_valid, 0);
    check("post_rst_ready", b15.ready, 1);
    check("post_rst_credit", b15.credit, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
